// File: rtl/regfile_2w2r_sb.sv
// regfile_2w2r_sb: two-write, two-read register file with a per-register busy
// scoreboard. Decode reads operands and claims a destination; writeback writes
// the result and retires the claim.
// Optional build macro RF_BYPASS_EN: same-cycle write data (and cleared busy)
// is forwarded combinationally to the read ports.
module regfile_2w2r_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rg_wrt_en0,
   input  logic [ADDR_W-1:0] rg_wrt_addr0,
   input  logic [DATA_W-1:0] rg_wrt_data0,
   input  logic              rg_wrt_en1,
   input  logic [ADDR_W-1:0] rg_wrt_addr1,
   input  logic [DATA_W-1:0] rg_wrt_data1,
   input  logic              rg_clm_en,
   input  logic [ADDR_W-1:0] rg_clm_addr,
   input  logic [ADDR_W-1:0] rg_rd_addr1,
   input  logic [ADDR_W-1:0] rg_rd_addr2,
   output logic [DATA_W-1:0] rg_rd_data1,
   output logic [DATA_W-1:0] rg_rd_data2,
   output logic              rg_rd_busy1,
   output logic              rg_rd_busy2,
   output logic              rg_clm_conflict
);

   localparam int unsigned DEPTH   = 2 ** ADDR_W;
   localparam bit          ZERO_EN = (ZERO_REG != 0);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic              conflict_q, conflict_d;

   // Effective write/claim strobes; address 0 is inert when hardwired to zero.
   logic wr0_ok, wr1_ok, clm_ok, wr0_live;

   // Qualify write and claim strobes; port 0 is dropped when port 1 hits the same address.
   always_comb begin
      wr0_ok   = rg_wrt_en0 && !(ZERO_EN && (rg_wrt_addr0 == '0));
      wr1_ok   = rg_wrt_en1 && !(ZERO_EN && (rg_wrt_addr1 == '0));
      clm_ok   = rg_clm_en  && !(ZERO_EN && (rg_clm_addr  == '0));
      wr0_live = wr0_ok && !(wr1_ok && (rg_wrt_addr1 == rg_wrt_addr0));
   end

   // Scoreboard next state: writebacks retire claims, a new claim wins over a retire.
   always_comb begin
      busy_d     = busy_q;
      conflict_d = 1'b0;
      if (wr0_ok) busy_d[rg_wrt_addr0] = 1'b0;
      if (wr1_ok) busy_d[rg_wrt_addr1] = 1'b0;
      if (clm_ok) begin
         busy_d[rg_clm_addr] = 1'b1;
         // WAW only counts if the old producer is not retiring this very cycle.
         conflict_d = busy_q[rg_clm_addr]
                      && !(wr0_ok && (rg_wrt_addr0 == rg_clm_addr))
                      && !(wr1_ok && (rg_wrt_addr1 == rg_clm_addr));
      end
   end

   // Register array storage with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         if (wr0_live) regs_q[rg_wrt_addr0] <= rg_wrt_data0;
         if (wr1_ok)   regs_q[rg_wrt_addr1] <= rg_wrt_data1;
      end
   end

   // Scoreboard and conflict flag state.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] ra);
      logic [DATA_W-1:0] v;
      v = regs_q[ra];
`ifdef RF_BYPASS_EN
      // Reset clears the array at the edge, so nothing is forwarded during it.
      if (!reset && wr0_ok && (rg_wrt_addr0 == ra)) v = rg_wrt_data0;
      if (!reset && wr1_ok && (rg_wrt_addr1 == ra)) v = rg_wrt_data1;
`endif
      if (ZERO_EN && (ra == '0)) v = '0;
      return v;
   endfunction

   function automatic logic read_busy(input logic [ADDR_W-1:0] ra);
      logic b;
      b = busy_q[ra];
`ifdef RF_BYPASS_EN
      if (!reset && ((wr0_ok && (rg_wrt_addr0 == ra)) || (wr1_ok && (rg_wrt_addr1 == ra)))) begin
         b = clm_ok && (rg_clm_addr == ra);
      end
`endif
      if (ZERO_EN && (ra == '0)) b = 1'b0;
      return b;
   endfunction

   // Combinational read ports.
   always_comb begin
      rg_rd_data1     = read_data(rg_rd_addr1);
      rg_rd_data2     = read_data(rg_rd_addr2);
      rg_rd_busy1     = read_busy(rg_rd_addr1);
      rg_rd_busy2     = read_busy(rg_rd_addr2);
      rg_clm_conflict = conflict_q;
   end

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Self-checking bench for regfile_2w2r_sb. Two instances share all inputs:
// index 0 has ZERO_REG=1, index 1 has ZERO_REG=0. A behavioural model tracks
// both; a negedge compare process checks every output each cycle, and a
// directed sequence pins the model with literal expectations.
module tb_regfile_2w2r_sb;

   logic        clk, reset;
   logic        en0, en1, clm_en;
   logic [4:0]  a0, a1, ca, ra1, ra2;
   logic [31:0] d0, d1;

   logic [31:0] rd1 [2];
   logic [31:0] rd2 [2];
   logic        bz1 [2];
   logic        bz2 [2];
   logic        cf  [2];

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   regfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut_z (
      .clk(clk), .reset(reset),
      .rg_wrt_en0(en0), .rg_wrt_addr0(a0), .rg_wrt_data0(d0),
      .rg_wrt_en1(en1), .rg_wrt_addr1(a1), .rg_wrt_data1(d1),
      .rg_clm_en(clm_en), .rg_clm_addr(ca),
      .rg_rd_addr1(ra1), .rg_rd_addr2(ra2),
      .rg_rd_data1(rd1[0]), .rg_rd_data2(rd2[0]),
      .rg_rd_busy1(bz1[0]), .rg_rd_busy2(bz2[0]),
      .rg_clm_conflict(cf[0])
   );

   regfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_nz (
      .clk(clk), .reset(reset),
      .rg_wrt_en0(en0), .rg_wrt_addr0(a0), .rg_wrt_data0(d0),
      .rg_wrt_en1(en1), .rg_wrt_addr1(a1), .rg_wrt_data1(d1),
      .rg_clm_en(clm_en), .rg_clm_addr(ca),
      .rg_rd_addr1(ra1), .rg_rd_addr2(ra2),
      .rg_rd_data1(rd1[1]), .rg_rd_data2(rd2[1]),
      .rg_rd_busy1(bz1[1]), .rg_rd_busy2(bz2[1]),
      .rg_clm_conflict(cf[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_regs [2][32];
   logic        m_busy [2][32];
   logic        m_conf [2];

   function automatic bit zr(input int z);
      return z == 0;
   endfunction

   always @(posedge clk) begin : model
      bit w0, w1, c;
      for (int z = 0; z < 2; z++) begin
         if (reset) begin
            for (int i = 0; i < 32; i++) begin
               m_regs[z][i] = '0;
               m_busy[z][i] = 1'b0;
            end
            m_conf[z] = 1'b0;
         end else begin
            w0 = en0 && !(zr(z) && a0 == 0);
            w1 = en1 && !(zr(z) && a1 == 0);
            c  = clm_en && !(zr(z) && ca == 0);
            m_conf[z] = c && m_busy[z][ca] && !(w0 && a0 == ca) && !(w1 && a1 == ca);
            if (w0) begin m_regs[z][a0] = d0; m_busy[z][a0] = 1'b0; end
            if (w1) begin m_regs[z][a1] = d1; m_busy[z][a1] = 1'b0; end
            if (c) m_busy[z][ca] = 1'b1;
         end
      end
   end

   function automatic logic [31:0] exp_data(input int z, input logic [4:0] a);
      logic [31:0] v;
      v = m_regs[z][a];
`ifdef RF_BYPASS_EN
      if (!reset && en0 && a0 == a) v = d0;
      if (!reset && en1 && a1 == a) v = d1;
`endif
      if (zr(z) && a == 0) v = '0;
      return v;
   endfunction

   function automatic logic exp_busy(input int z, input logic [4:0] a);
      logic b;
      b = m_busy[z][a];
`ifdef RF_BYPASS_EN
      if (!reset && ((en0 && a0 == a) || (en1 && a1 == a))) b = clm_en && ca == a;
`endif
      if (zr(z) && a == 0) b = 1'b0;
      return b;
   endfunction

   // Every-cycle compare against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int z = 0; z < 2; z++) begin
            chk(zr(z) ? "z.data1" : "nz.data1", rd1[z], exp_data(z, ra1));
            chk(zr(z) ? "z.data2" : "nz.data2", rd2[z], exp_data(z, ra2));
            chk(zr(z) ? "z.busy1" : "nz.busy1", {31'b0, bz1[z]}, {31'b0, exp_busy(z, ra1)});
            chk(zr(z) ? "z.busy2" : "nz.busy2", {31'b0, bz2[z]}, {31'b0, exp_busy(z, ra2)});
            chk(zr(z) ? "z.conf" : "nz.conf", {31'b0, cf[z]}, {31'b0, m_conf[z]});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en0 = 0; en1 = 0; clm_en = 0;
      a0 = 0; a1 = 0; ca = 0; d0 = 0; d1 = 0;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   initial begin
      idle();
      ra1 = 0; ra2 = 0;
      // Reset with a write held: reset wins.
      reset = 1; en0 = 1; a0 = 5'd18; d0 = 32'h45; ra1 = 5'd18;
      step();
      chk_en = 1;
      step();
      at_neg();
      chk("rst.data1", rd1[0], 32'h0);
      chk("rst.busy1", {31'b0, bz1[0]}, 32'h0);
      chk("rst.conf", {31'b0, cf[0]}, 32'h0);
      step();
      reset = 0;
      at_neg();
`ifdef RF_BYPASS_EN
      chk("rel.pre", rd1[0], 32'h45);
`else
      chk("rel.pre", rd1[0], 32'h0);
`endif
      step();
      idle();
      at_neg();
      chk("rel.post", rd1[0], 32'h45);

      // Dual-write collision and distinct addresses.
      step();
      en0 = 1; en1 = 1; a0 = 5'd5; a1 = 5'd5; d0 = 32'h89; d1 = 32'hAA;
      step();
      idle(); ra1 = 5'd5;
      at_neg();
      chk("coll.r5", rd1[0], 32'hAA);
      step();
      en0 = 1; a0 = 5'd3; d0 = 32'h11; en1 = 1; a1 = 5'd7; d1 = 32'h22;
      step();
      idle(); ra1 = 5'd3; ra2 = 5'd7;
      at_neg();
      chk("dist.r3", rd1[0], 32'h11);
      chk("dist.r7", rd2[0], 32'h22);

      // Zero register vs ordinary register 0.
      step();
      en0 = 1; a0 = 5'd0; d0 = 32'h32; clm_en = 1; ca = 5'd0;
      step();
      idle(); ra1 = 5'd0;
      at_neg();
      chk("zero.data", rd1[0], 32'h0);
      chk("zero.busy", {31'b0, bz1[0]}, 32'h0);
      chk("nz0.data", rd1[1], 32'h32);
      chk("nz0.busy", {31'b0, bz1[1]}, 32'h1);

      // Scoreboard: claim, conflict pulse, retire, claim-wins.
      step();
      clm_en = 1; ca = 5'd9; ra1 = 5'd9;
      step();
      idle();
      at_neg();
      chk("sb.busy", {31'b0, bz1[0]}, 32'h1);
      chk("sb.noconf", {31'b0, cf[0]}, 32'h0);
      step();
      clm_en = 1; ca = 5'd9;
      step();
      idle();
      at_neg();
      chk("sb.conf", {31'b0, cf[0]}, 32'h1);
      step();
      at_neg();
      chk("sb.conf1cyc", {31'b0, cf[0]}, 32'h0);
      chk("sb.stillbusy", {31'b0, bz1[0]}, 32'h1);
      step();
      en0 = 1; a0 = 5'd9; d0 = 32'h7B;
      step();
      idle();
      at_neg();
      chk("sb.ret.busy", {31'b0, bz1[0]}, 32'h0);
      chk("sb.ret.data", rd1[0], 32'h7B);
      step();
      clm_en = 1; ca = 5'd9;
      step();
      clm_en = 1; ca = 5'd9; en1 = 1; a1 = 5'd9; d1 = 32'h5;
      step();
      idle();
      at_neg();
      chk("sb.cw.busy", {31'b0, bz1[0]}, 32'h1);
      chk("sb.cw.conf", {31'b0, cf[0]}, 32'h0);

      // Bypass visibility on reg 12.
      step();
      en0 = 1; a0 = 5'd12; d0 = 32'h55; clm_en = 1; ca = 5'd12;
      step();
      idle();
      en1 = 1; a1 = 5'd12; d1 = 32'h1234; ra2 = 5'd12;
      at_neg();
`ifdef RF_BYPASS_EN
      chk("byp.pre.data", rd2[0], 32'h1234);
      chk("byp.pre.busy", {31'b0, bz2[0]}, 32'h0);
`else
      chk("byp.pre.data", rd2[0], 32'h55);
      chk("byp.pre.busy", {31'b0, bz2[0]}, 32'h1);
`endif
      step();
      idle();
      at_neg();
      chk("byp.post.data", rd2[0], 32'h1234);
      chk("byp.post.busy", {31'b0, bz2[0]}, 32'h0);

      // Reset mid-claim; assertion between edges has no effect yet.
      step();
      en0 = 1; a0 = 5'd4; d0 = 32'hABC; clm_en = 1; ca = 5'd4;
      step();
      idle(); clm_en = 1; ca = 5'd6;
      step();
      idle(); ra1 = 5'd4; ra2 = 5'd6;
      reset = 1;
      at_neg();
      chk("mid.busy4", {31'b0, bz1[0]}, 32'h1);
      chk("mid.busy6", {31'b0, bz2[0]}, 32'h1);
      chk("mid.data4", rd1[0], 32'hABC);
      step();
      reset = 0;
      at_neg();
      chk("mid.rst.busy4", {31'b0, bz1[0]}, 32'h0);
      chk("mid.rst.busy6", {31'b0, bz2[0]}, 32'h0);
      chk("mid.rst.data4", rd1[0], 32'h0);

      // Randomized traffic on a narrow address range to force collisions.
      for (int n = 0; n < 3000; n++) begin
         step();
         reset  = ($urandom_range(0, 99) == 0);
         en0    = 1'($urandom_range(0, 1));
         en1    = 1'($urandom_range(0, 1));
         clm_en = 1'($urandom_range(0, 1));
         a0     = 5'($urandom_range(0, 7));
         a1     = 5'($urandom_range(0, 7));
         ca     = 5'($urandom_range(0, 7));
         ra1    = 5'($urandom_range(0, 7));
         ra2    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         d0     = $urandom;
         d1     = $urandom;
      end
      step();
      idle();
      reset = 0;
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
